chrisruk_scroll_sched: RTL and testbench
========================================

// Module: chrisruk_scroll_sched
// PURPOSE
//  Scroll scheduler for the 8x8 WS2812-style matrix serializer. Holds a short message of glyph
//  codes, issues one frame request per display refresh (left glyph, right glyph, shift 0..7), and
//  advances the scroll after a programmable number of repeated frames. Sits between the host/IO
//  pins and the serializer; the serializer owns font lookup and bitstream timing.
// PARAMETERS
//  MSG_LEN     16     message buffer depth in glyphs (2..64); AW = $clog2(MSG_LEN) localparam
//  GLYPH_W     5      glyph code width (font index)
//  BLANK_CODE  0      glyph code inserted as gap when LOOP_GAP_EN defined
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  reset        in   1        asynchronous, active-low reset
//  enable       in   1        1 = run scroll; 0 = finish current frame then idle
//  wr_en        in   1        message buffer write strobe
//  wr_addr      in   AW       write address
//  wr_data      in   GLYPH_W  glyph code to write
//  msg_len      in   AW+1     valid glyphs; 0 treated as 1, >MSG_LEN clamped to MSG_LEN
//  speed        in   4        frames per shift step minus 1 (0 = advance every frame)
//  frame_ack    in   1        serializer accepts request (sampled while frame_req=1)
//  frame_done   in   1        1-cycle pulse: serializer finished shifting out the frame
//  frame_req    out  1        frame request valid
//  glyph_left   out  GLYPH_W  glyph shifted out to the left
//  glyph_right  out  GLYPH_W  glyph entering from the right
//  shift        out  3        column shift, 0 = glyph_left fully shown
//  busy         out  1        1 whenever state != IDLE
//  wrap_pulse   out  1        1-cycle pulse when letter index wraps to 0
// BEHAVIOUR
//  - Reset: frame_req=0, busy=0, wrap_pulse=0, shift=0, glyph_left=glyph_right=0, idx=0,
//    hold_cnt=0, buffer entries all 0, state IDLE. Reset mid-frame aborts; frame_done ignored.
//  - FSM: IDLE -> REQ when enable=1. REQ: frame_req=1; outputs latched on REQ entry and held
//    stable until frame_ack. REQ -> WAIT on frame_ack (frame_req=0 the next cycle).
//    WAIT -> ADV on frame_done. ADV (1 cycle) -> REQ if enable=1, else IDLE.
//  - ADV: if hold_cnt==speed, hold_cnt=0 and scroll step; else hold_cnt+=1 and the same frame
//    repeats. Scroll step: shift<7 -> shift+1; shift==7 -> shift=0, idx=(idx==L-1)?0:idx+1,
//    where L = effective msg_len. wrap_pulse=1 in the ADV cycle when idx wraps to 0.
//  - glyph_left=buf[idx], glyph_right=buf[(idx+1)%L], sampled on REQ entry. L=1 -> both buf[0].
//  - Writes accepted in any state, 1-cycle write; they affect the next REQ entry, never the
//    frame in flight. A write and a REQ entry on the same cycle -> REQ sees the old data.
//  - msg_len/speed sampled only in ADV; if idx >= new L, then idx=0 at the next step.
//  - frame_done outside WAIT and frame_ack outside REQ are ignored.
//  - enable falling in REQ before ack: request stays until acked (no retraction).
// CONFIGURATION
//  LOOP_GAP_EN defined: virtual sequence length L+1; position L reads BLANK_CODE, so the scroll
//    shows ..., last, blank, first, ...; wrap_pulse fires when idx goes L -> 0.
//  LOOP_GAP_EN undefined: last glyph scrolls directly into glyph 0; BLANK_CODE unused.
// TESTING
//  1 reset=0 mid-WAIT, release -> all outputs 0, state IDLE, first REQ shows buf[0],buf[1],shift 0.
//  2 msg {3,7,9}, L=3, speed=0, ack/done each frame -> 24 frames cycle shift 0..7 over pairs
//    (3,7),(7,9),(9,3); wrap_pulse exactly once per 24 frames.
//  3 speed=2 -> each (glyphs,shift) tuple requested 3 times before shift increments.
//  4 hold frame_ack=0 for 10 cycles -> frame_req and outputs stable for all 10; write to buf[idx]
//    during that window does not change glyph_left until the next request.
//  5 enable=0 during WAIT -> after frame_done, one ADV, then IDLE, busy=0, no further frame_req.
//  6 LOOP_GAP_EN, msg {1,2}, BLANK_CODE=0 -> pairs (1,2),(2,0),(0,1); msg_len=0 -> behaves as L=1.

Source files
------------

// File: rtl/chrisruk_scroll_sched.sv
// rtl/chrisruk_scroll_sched.sv - scroll scheduler issuing one frame request per refresh to the matrix serializer
// Optional feature macro LOOP_GAP_EN: inserts BLANK_CODE between the last and first glyph of the loop.
module chrisruk_scroll_sched #(
  parameter int                 MSG_LEN    = 16,
  parameter int                 GLYPH_W    = 5,
  parameter logic [GLYPH_W-1:0] BLANK_CODE = '0,
  localparam int                AW         = $clog2(MSG_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [GLYPH_W-1:0] wr_data,
  input  logic [AW:0]        msg_len,
  input  logic [3:0]         speed,
  input  logic               frame_ack,
  input  logic               frame_done,
  output logic               frame_req,
  output logic [GLYPH_W-1:0] glyph_left,
  output logic [GLYPH_W-1:0] glyph_right,
  output logic [2:0]         shift,
  output logic               busy,
  output logic               wrap_pulse
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ADV} state_t;

  localparam logic [AW:0] MAX_LEN = (AW+1)'(MSG_LEN);

  state_t             state_q, state_d;
  logic [GLYPH_W-1:0] mem_q [MSG_LEN];
  logic [AW:0]        idx_q, idx_d, right_idx, len_eff, wrap_lim;
  logic [2:0]         shift_d;
  logic [3:0]         hold_q, hold_d;
  logic               load;
  logic [GLYPH_W-1:0] left_d, right_d;

  always_comb begin
    if (msg_len == '0)          len_eff = (AW+1)'(1);
    else if (msg_len > MAX_LEN) len_eff = MAX_LEN;
    else                        len_eff = msg_len;
`ifdef LOOP_GAP_EN
    wrap_lim = len_eff;          // virtual position L holds the blank gap
`else
    wrap_lim = len_eff - 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift;
    hold_d     = hold_q;
    load       = 1'b0;
    wrap_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = REQ;
          load    = 1'b1;
        end
      end
      REQ:  if (frame_ack) state_d = WAIT;
      WAIT: if (frame_done) state_d = ADV;
      ADV: begin
        if (hold_q >= speed) begin
          hold_d = '0;
          if (shift != 3'd7) begin
            shift_d = shift + 3'd1;
          end else begin
            shift_d = '0;
            // >= also catches an index left stranded by a shrunken msg_len
            if (idx_q >= wrap_lim) begin
              idx_d      = '0;
              wrap_pulse = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
        state_d = enable ? REQ : IDLE;
        load    = enable;
      end
      default: state_d = IDLE;
    endcase

    right_idx = (idx_d >= wrap_lim) ? '0 : idx_d + 1'b1;
    left_d    = (idx_d < MAX_LEN) ? mem_q[idx_d[AW-1:0]] : BLANK_CODE;
    right_d   = (right_idx < MAX_LEN) ? mem_q[right_idx[AW-1:0]] : BLANK_CODE;
`ifdef LOOP_GAP_EN
    if (idx_d >= len_eff)     left_d  = BLANK_CODE;
    if (right_idx >= len_eff) right_d = BLANK_CODE;
`endif
  end

  // Buffer reads above see pre-write contents, so a same-cycle write misses the frame being latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shift       <= '0;
      hold_q      <= '0;
      glyph_left  <= '0;
      glyph_right <= '0;
      for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift   <= shift_d;
      hold_q  <= hold_d;
      if (load) begin
        glyph_left  <= left_d;
        glyph_right <= right_d;
      end
      if (wr_en && ({1'b0, wr_addr} < MAX_LEN)) mem_q[wr_addr] <= wr_data;
    end
  end

  assign frame_req = (state_q == REQ);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_chrisruk_scroll_sched.sv
// tb/tb_chrisruk_scroll_sched.sv - bench for chrisruk_scroll_sched: behavioural scroll model plus directed and random stimulus
// Honours LOOP_GAP_EN the same way as the design.
module tb_chrisruk_scroll_sched;
  localparam int MSG_LEN = 16;
  localparam int GW      = 5;
  localparam int AW      = $clog2(MSG_LEN);
  localparam int BLANK   = 0;
`ifdef LOOP_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          enable     = 1'b0;
  logic          wr_en      = 1'b0;
  logic [AW-1:0] wr_addr    = '0;
  logic [GW-1:0] wr_data    = '0;
  logic [AW:0]   msg_len    = (AW+1)'(3);
  logic [3:0]    speed      = '0;
  logic          frame_ack  = 1'b0;
  logic          frame_done = 1'b0;
  logic          frame_req, busy, wrap_pulse;
  logic [GW-1:0] glyph_left, glyph_right;
  logic [2:0]    shift;

  always #5 clk = ~clk;

  chrisruk_scroll_sched #(.MSG_LEN(MSG_LEN), .GLYPH_W(GW), .BLANK_CODE(GW'(BLANK))) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .msg_len(msg_len), .speed(speed), .frame_ack(frame_ack),
    .frame_done(frame_done), .frame_req(frame_req), .glyph_left(glyph_left),
    .glyph_right(glyph_right), .shift(shift), .busy(busy), .wrap_pulse(wrap_pulse)
  );

  int checks = 0, errors = 0, wrap_cnt = 0;

  // Model: phase 0 idle, 1 requesting, 2 serializer busy, 3 advancing.
  int m_st = 0, pos = 0, sh = 0, hold = 0, n_pos = 0, n_sh = 0, n_hold = 0;
  int exp_l = 0, exp_r = 0;
  bit exp_wrap = 1'b0;
  int mem [MSG_LEN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic int eff_len(input int m);
    if (m == 0) return 1;
    if (m > MSG_LEN) return MSG_LEN;
    return m;
  endfunction

  function automatic int glyph_at(input int p, input int len);
    if ((GAP == 1 && p >= len) || p >= MSG_LEN) return BLANK;
    return mem[p];
  endfunction

  task automatic load_tuple(input int len);
    int seq = len + GAP;
    exp_l = glyph_at(pos, len);
    exp_r = glyph_at((pos + 1 >= seq) ? 0 : pos + 1, len);
  endtask

  task automatic plan_step(input int len);
    int seq = len + GAP;
    n_pos = pos; n_sh = sh; n_hold = hold;
    if (hold >= int'(speed)) begin
      n_hold = 0;
      if (sh < 7) n_sh = sh + 1;
      else begin
        n_sh = 0;
        if (pos >= seq - 1) begin n_pos = 0; exp_wrap = 1'b1; end
        else n_pos = pos + 1;
      end
    end else begin
      n_hold = hold + 1;
    end
  endtask

  task automatic model_edge();
    int len = eff_len(int'(msg_len));
    exp_wrap = 1'b0;
    if (!reset) begin
      m_st = 0; pos = 0; sh = 0; hold = 0; exp_l = 0; exp_r = 0;
      foreach (mem[i]) mem[i] = 0;
      return;
    end
    case (m_st)
      0: if (enable) begin m_st = 1; load_tuple(len); end
      1: if (frame_ack) m_st = 2;
      2: if (frame_done) begin m_st = 3; plan_step(len); end
      default: begin
        pos = n_pos; sh = n_sh; hold = n_hold;
        if (enable) begin m_st = 1; load_tuple(len); end
        else m_st = 0;
      end
    endcase
    if (wr_en) mem[wr_addr] = int'(wr_data);
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = GW'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_frame(input int ack_dly, input int done_dly);
    frame_ack = 1'b0;
    repeat (ack_dly) step();
    frame_ack = 1'b1; step(); frame_ack = 1'b0;
    repeat (done_dly) step();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    step();
  endtask

  always @(posedge clk) begin
    #1;
    chk("frame_req", 32'(frame_req), 32'(m_st == 1));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(exp_wrap));
    chk("shift", 32'(shift), sh);
    chk("glyph_left", 32'(glyph_left), exp_l);
    chk("glyph_right", 32'(glyph_right), exp_r);
    if (wrap_pulse === 1'b1) wrap_cnt++;
  end

  initial begin
    int pl[3] = '{3, 7, 9};
    int pr[3] = '{7, 9, 3};
    int w0;
    @(negedge clk);
    step();
    reset = 1'b1; step();
    chk("reset_req", 32'(frame_req), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_shift", 32'(shift), 0);
    chk("reset_left", 32'(glyph_left), 0);

    // three-glyph loop at full speed
    wr(0, 3); wr(1, 7); wr(2, 9);
    enable = 1'b1; step();
    w0 = wrap_cnt;
    for (int k = 0; k < 24; k++) begin
      chk("loop_left", 32'(glyph_left), pl[k/8]);
      chk("loop_right", 32'(glyph_right), pr[k/8]);
      chk("loop_shift", 32'(shift), k % 8);
      do_frame(k % 3, (k * 5) % 4);
    end
    chk("loop_wraps", wrap_cnt - w0, 1);

    // each frame repeated three times
    speed = 4'd2;
    for (int k = 0; k < 9; k++) begin
      chk("repeat_shift", 32'(shift), k / 3);
      chk("repeat_left", 32'(glyph_left), 3);
      do_frame(1, 1);
    end

    // stalled ack with a write to the shown glyph
    speed = 4'd0;
    frame_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_req", 32'(frame_req), 1);
      chk("stall_left", 32'(glyph_left), 3);
      chk("stall_shift", 32'(shift), 3);
      if (i == 4) wr(0, 12);
      else step();
    end
    do_frame(0, 2);
    chk("post_write_left", 32'(glyph_left), 12);
    chk("post_write_shift", 32'(shift), 4);

    // disable while the serializer is busy
    frame_ack = 1'b1; step(); frame_ack = 1'b0;
    enable = 1'b0; step();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("idle_req", 32'(frame_req), 0);
      chk("idle_busy", 32'(busy), 0);
      frame_done = (i % 2 == 0); frame_ack = (i % 3 == 0);
      step();
    end
    frame_done = 1'b0; frame_ack = 1'b0;
    chk("idle_shift", 32'(shift), 5);

    // reset while the serializer is busy
    enable = 1'b1; step();
    frame_ack = 1'b1; step(); frame_ack = 1'b0;
    step();
    reset = 1'b0; step();
    chk("midreset_req", 32'(frame_req), 0);
    chk("midreset_shift", 32'(shift), 0);
    chk("midreset_right", 32'(glyph_right), 0);
    reset = 1'b1; enable = 1'b0; frame_done = 1'b1; step(); frame_done = 1'b0;
    wr(0, 5); wr(1, 6);
    enable = 1'b1; step();
    chk("restart_left", 32'(glyph_left), 5);
    chk("restart_right", 32'(glyph_right), 6);
    chk("restart_shift", 32'(shift), 0);

    // msg_len 0 acts as a single glyph
    msg_len = '0;
    do_frame(0, 0);
    w0 = wrap_cnt;
    for (int k = 0; k < 8; k++) begin
      chk("single_left", 32'(glyph_left), 5);
      chk("single_right", 32'(glyph_right), 5);
      chk("single_shift", 32'(shift), (k + 1) % 8);
      do_frame(0, 1);
    end
    chk("single_wraps", wrap_cnt - w0, 1);

`ifdef LOOP_GAP_EN
    begin
      int gl[3] = '{1, 2, 0};
      int gr[3] = '{2, 0, 1};
      reset = 1'b0; enable = 1'b0; step();
      reset = 1'b1; step();
      wr(0, 1); wr(1, 2);
      msg_len = (AW+1)'(2);
      enable = 1'b1; step();
      w0 = wrap_cnt;
      for (int k = 0; k < 24; k++) begin
        chk("gap_left", 32'(glyph_left), gl[k/8]);
        chk("gap_right", 32'(glyph_right), gr[k/8]);
        do_frame(0, 1);
      end
      chk("gap_wraps", wrap_cnt - w0, 1);
    end
`endif

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      enable     = ($urandom_range(0, 9) != 0);
      frame_ack  = ($urandom_range(0, 2) == 0);
      frame_done = ($urandom_range(0, 2) == 0);
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_addr    = AW'($urandom_range(0, MSG_LEN - 1));
      wr_data    = GW'($urandom);
      if ((m_st == 1 || m_st == 2) && $urandom_range(0, 7) == 0) begin
        msg_len = (AW+1)'($urandom_range(0, 2 * MSG_LEN - 1));
        speed   = 4'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 499) != 0);
      step();
    end
    reset = 1'b1; wr_en = 1'b0; frame_ack = 1'b0; frame_done = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
